// File: rtl/inst_mem_responder.sv
// Purpose : instruction-fetch memory responder; 64-bit word store with a byte-masked backdoor write port.
// Latency : rvalid rises LATENCY cycles after the address-accept cycle; one transaction in flight.
// Backpr. : rdata/rresp held with rvalid until rready; arready stays low from accept until the cycle after the data handshake.
module inst_mem_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    // Legal range 1..15; the wait counter is 4 bits wide.
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arvalid,
    output logic        arready,
    input  logic [63:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    input  logic        wen,
    input  logic [63:0] waddr,
    input  logic [63:0] wdata,
    input  logic [7:0]  wmask
);
    localparam int         IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] addr_q;

    // Contents survive reset so a loaded program is not lost.
    logic [63:0] mem [DEPTH_WORDS];

    logic [63:0]      rd_addr;
    logic [63:0]      rd_off;
    logic             rd_ok;
    logic [IDX_W-1:0] rd_idx;
    logic [63:0]      rd_word;
    logic [63:0]      wr_off;
    logic             wr_ok;
    logic [IDX_W-1:0] wr_idx;

    // Read-side decode: in IDLE the live address feeds the LATENCY==1 capture,
    // afterwards the latched address. Range is checked on the full 64-bit
    // offset so addresses below BASE_ADDR cannot wrap into the store.
    always_comb begin
        rd_addr = (state == IDLE) ? araddr : addr_q;
        rd_off  = rd_addr - BASE_ADDR;
        rd_ok   = (rd_addr >= BASE_ADDR) && ((rd_off >> 3) < 64'(DEPTH_WORDS));
        rd_idx  = rd_off[IDX_W+2:3];
        rd_word = rd_ok ? mem[rd_idx] : 64'd0;
    end

    // Backdoor decode, same range rule as the read side.
    always_comb begin
        wr_off = waddr - BASE_ADDR;
        wr_ok  = (waddr >= BASE_ADDR) && ((wr_off >> 3) < 64'(DEPTH_WORDS));
        wr_idx = wr_off[IDX_W+2:3];
    end

    // Backdoor byte-lane write; non-blocking, so a capture on the same edge sees the old word.
    always_ff @(posedge clk) begin
        if (!rst && wen && wr_ok) begin
            for (int i = 0; i < 8; i++) begin
                if (wmask[i]) begin
                    mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Request FSM with registered handshake outputs; response captured on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= 64'd0;
            rresp   <= RESP_OKAY;
            cnt     <= 4'd0;
            addr_q  <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (arready && arvalid) begin
                        addr_q  <= araddr;
                        arready <= 1'b0;
                        if (LATENCY == 1) begin
                            state  <= RESP;
                            rvalid <= 1'b1;
                            rdata  <= rd_word;
                            rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT_M1;
                        end
                    end else begin
                        // Also covers the first cycle out of reset.
                        arready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state  <= RESP;
                        rvalid <= 1'b1;
                        rdata  <= rd_word;
                        rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        cnt    <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rready) begin
                        state   <= IDLE;
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    arready <= 1'b0;
                    rvalid  <= 1'b0;
                end
            endcase
        end
    end
endmodule
